rr_grant_arbiter: RTL

//   Round-robin arbiter that shares one 16-way select resource between N requesters.

---
 rtl/rr_arb_pkg.sv | 18 +
 rtl/rr_prio_pick.sv | 38 +++
 rtl/rr_grant_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin grant arbiter.
// Optional hold-timeout is enabled by defining RR_ARB_TIMEOUT_EN.
package rr_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} rr_state_t;

  localparam int RR_N           = 16;
  localparam int RR_IDX_W       = 4;
  localparam int RR_TIMEOUT_CYC = 255;

  function automatic logic [RR_N-1:0] onehot_of(input logic [RR_IDX_W-1:0] idx);
    logic [RR_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin picker: first set request strictly after 'last',
// wrapping N-1 -> 0. Rotate, priority-encode, un-rotate.
import rr_arb_pkg::*;

module rr_prio_pick #(
  parameter int N     = RR_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] pick
);

  localparam int SW = IDX_W + 1;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [SW-1:0]  start;
  logic [SW-1:0]  enc;
  logic [SW-1:0]  sum;

  always_comb begin
    start = (last == IDX_W'(N - 1)) ? '0 : ({1'b0, last} + SW'(1));
    dbl   = {req, req};
    rot   = dbl[start +: N];
    any   = |req;
    enc   = '0;
    // Descending scan so the lowest rotated position wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) enc = SW'(i);
    end
    sum = start + enc;
    if (sum >= SW'(N)) sum = sum - SW'(N);
    pick = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter issuing one registered grant (index, one-hot, one-cold).
// Define RR_ARB_TIMEOUT_EN to force-release grants held TIMEOUT_CYC cycles.
import rr_arb_pkg::*;

module rr_grant_arbiter #(
  parameter int N           = RR_N,
  parameter int IDX_W       = $clog2(N),
  parameter int TIMEOUT_CYC = RR_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_onehot,
  output logic [N-1:0]     gnt_onecold,
  output logic             timeout,
  output rr_state_t        state
);

  rr_state_t        state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [N-1:0]     onehot_q, onehot_d;
  logic [IDX_W-1:0] pick_last, pick;
  logic             any, expire, new_grant, rel;
  logic [RR_N-1:0]  oh_full;

  // A releasing owner is the new pointer, so searching from it ranks it last.
  assign pick_last = (state_q == GRANT) ? idx_q : last_q;

  rr_prio_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req  (req),
    .last (pick_last),
    .any  (any),
    .pick (pick)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    new_grant = 1'b0;
    rel       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          idx_d     = pick;
          valid_d   = 1'b1;
          state_d   = GRANT;
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        rel = done | ~req[idx_q] | expire;
        if (rel) begin
          last_d = idx_q;
          if (any) begin
            idx_d     = pick;
            new_grant = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    oh_full  = onehot_of(RR_IDX_W'(idx_d));
    onehot_d = valid_d ? oh_full[N-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= IDX_W'(N - 1);
      idx_q    <= '0;
      valid_q  <= 1'b0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      onehot_q <= onehot_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] hold_cnt;
  logic          timeout_q, timeout_d;

  assign expire    = (state_q == GRANT) && (hold_cnt == CW'(TIMEOUT_CYC));
  // A done or abandon coinciding with expiry is an ordinary release.
  assign timeout_d = expire & ~done & req[idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
      if (new_grant)
        hold_cnt <= CW'(1);
      else if (state_q == GRANT && hold_cnt != CW'(TIMEOUT_CYC))
        hold_cnt <= hold_cnt + CW'(1);
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign state       = state_q;
  assign gnt_valid   = valid_q;
  assign gnt_idx     = idx_q;
  assign gnt_onehot  = onehot_q;
  assign gnt_onecold = ~onehot_q;

endmodule
